// File: rtl/spi_cmd_pkg.sv
// Shared opcode map, FSM encoding and decoded-command kinds for the SPI command decoder.
package spi_cmd_pkg;

  localparam int DATA_W_DEF = 12;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_SAMPLE     = 4'h1;
  localparam logic [3:0] OP_LED        = 4'h2;
  localparam logic [3:0] OP_CLRERR     = 4'h3;
  localparam logic [3:0] OP_WRITE_BASE = 4'h4;
  localparam logic [3:0] OP_READ_BASE  = 4'h8;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC} state_t;

  typedef enum logic [2:0] {
    K_NOP, K_SAMPLE, K_LED, K_CLRERR, K_WRITE, K_READ, K_ILLEGAL
  } kind_t;

  // WRITE and READ each occupy an aligned block of four opcodes.
  function automatic kind_t decode_op(input logic [3:0] op);
    if (op == OP_NOP)                           return K_NOP;
    else if (op == OP_SAMPLE)                   return K_SAMPLE;
    else if (op == OP_LED)                      return K_LED;
    else if (op == OP_CLRERR)                   return K_CLRERR;
    else if (op[3:2] == OP_WRITE_BASE[3:2])     return K_WRITE;
    else if (op[3:2] == OP_READ_BASE[3:2])      return K_READ;
    else                                        return K_ILLEGAL;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_sample_counter.sv
// Free-running prescaled sample counter; advances once every SAMPLE_DIV clocks.
module sample_counter import spi_cmd_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_DIV = 2097152
) (
  input  logic              CLK_50,
  input  logic              RST,
  output logic [DATA_W-1:0] COUNT
);

  localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic [PW-1:0]     pre_q, pre_d;
  logic [DATA_W-1:0] count_q, count_d;

  always_comb begin
    pre_d   = pre_q + 1'b1;
    count_d = count_q;
    if (pre_q == PW'(SAMPLE_DIV - 1)) begin
      pre_d   = '0;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      pre_q   <= '0;
      count_q <= '0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Executes received SPI command words against a register file, LEDs and a sample counter,
// producing the reply payload for the next outgoing frame.
module spi_cmd_decoder import spi_cmd_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_DIV = 2097152,
  parameter int ERR_W      = 8
) (
  input  logic              CLK_50,
  input  logic              RST,
  input  logic [15:0]       RX_WORD,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              DONE,
  output logic [1:0]        LEDS,
  output logic [ERR_W-1:0]  ERR_CNT
);

  state_t                  state_q, state_d;
  kind_t                   kind_q, kind_d;
  logic [15:0]             cmd_q, cmd_d;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic [1:0]              leds_q, leds_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    done_q, done_d;
  logic [3:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DATA_W-1:0]       sample;
  logic [DATA_W-1:0]       arg;

  sample_counter #(.DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV)) u_sample (
    .CLK_50 (CLK_50),
    .RST    (RST),
    .COUNT  (sample)
  );

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
    return (e == '1) ? e : e + 1'b1;
  endfunction

  assign arg = DATA_W'(cmd_q[11:0]);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    leds_d  = leds_q;
    err_d   = err_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    // A word offered while busy is dropped and only counted.
    if (RX_VALID && state_q != ST_IDLE) err_d = sat_inc(err_d);
    case (state_q)
      ST_IDLE: if (RX_VALID) begin
        cmd_d   = RX_WORD;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        kind_d  = decode_op(cmd_q[15:12]);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (kind_q)
          K_SAMPLE:  tx_d = sample;
          K_LED:     begin leds_d = arg[1:0]; tx_d = arg; end
          K_CLRERR:  err_d = '0;
          K_WRITE:   begin regs_d[cmd_q[13:12]] = arg; tx_d = arg; end
          K_READ:    tx_d = regs_q[cmd_q[13:12]];
          K_ILLEGAL: begin err_d = sat_inc(err_d); tx_d = '1; end
          default:   ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      kind_q  <= K_NOP;
      cmd_q   <= '0;
      tx_q    <= '0;
      leds_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign RX_READY = (state_q == ST_IDLE);
  assign TX_DATA  = tx_q;
  assign DONE     = done_q;
  assign LEDS     = leds_q;
  assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder with a fast prescaler so the sample counter wraps quickly.
module tb_spi_cmd_decoder;

  logic        CLK_50 = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] RX_WORD = '0;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [11:0] TX_DATA;
  logic        DONE;
  logic [1:0]  LEDS;
  logic [7:0]  ERR_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  spi_cmd_decoder #(.DATA_W(12), .SAMPLE_DIV(4), .ERR_W(8)) dut (
    .CLK_50   (CLK_50),
    .RST      (RST),
    .RX_WORD  (RX_WORD),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .TX_DATA  (TX_DATA),
    .DONE     (DONE),
    .LEDS     (LEDS),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK_50 = ~CLK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one word and run it to completion; returns 1 ns after the DONE edge.
  task automatic send(input logic [15:0] w);
    RX_WORD  = w;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(RX_READY), 32'h1);
    chk({tag, "_tx"},    32'(TX_DATA),  32'h0);
    chk({tag, "_done"},  32'(DONE),     32'h0);
    chk({tag, "_leds"},  32'(LEDS),     32'h0);
    chk({tag, "_err"},   32'(ERR_CNT),  32'h0);
  endtask

  initial begin
    idle(2);
    chk_reset_vals("rst");
    RST = 1'b0;

    // WRITE reg1 with explicit latency checks
    RX_WORD = 16'h5ABC; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("wr_c1_done",  32'(DONE), 32'h0);
    chk("wr_c1_ready", 32'(RX_READY), 32'h0);
    tick();
    chk("wr_c2_done",  32'(DONE), 32'h0);
    tick();
    chk("wr_c3_done",  32'(DONE), 32'h1);
    chk("wr_c3_tx",    32'(TX_DATA), 32'hABC);
    chk("wr_c3_ready", 32'(RX_READY), 32'h1);
    tick();
    chk("wr_c4_done",  32'(DONE), 32'h0);
    chk("wr_c4_hold",  32'(TX_DATA), 32'hABC);

    send(16'h9000); chk("rd_reg1", 32'(TX_DATA), 32'hABC);
    send(16'h8000); chk("rd_reg0", 32'(TX_DATA), 32'h000);
    send(16'hB000); chk("rd_reg3", 32'(TX_DATA), 32'h000);

    send(16'h2003);
    chk("led3_leds", 32'(LEDS), 32'h3);
    chk("led3_tx",   32'(TX_DATA), 32'h003);
    send(16'h2001);
    chk("led1_leds", 32'(LEDS), 32'h1);
    send(16'h0FFF); chk("nop_tx", 32'(TX_DATA), 32'h001);

    send(16'hC123);
    chk("ill_tx",  32'(TX_DATA), 32'hFFF);
    chk("ill_err", 32'(ERR_CNT), 32'h1);
    send(16'h3000);
    chk("clr_err", 32'(ERR_CNT), 32'h0);
    chk("clr_tx",  32'(TX_DATA), 32'hFFF);

    // Overrun: second word offered during DECODE is dropped
    RX_WORD = 16'h4123; RX_VALID = 1'b1;
    tick();
    RX_WORD = 16'h5456;
    tick();
    RX_VALID = 1'b0;
    chk("ovr_err", 32'(ERR_CNT), 32'h1);
    tick();
    chk("ovr_done", 32'(DONE), 32'h1);
    chk("ovr_tx",   32'(TX_DATA), 32'h123);
    send(16'h9000); chk("ovr_reg1_kept", 32'(TX_DATA), 32'hABC);
    send(16'h8000); chk("ovr_reg0",      32'(TX_DATA), 32'h123);

    // Back-to-back: accepted in cycle 0 and cycle 3
    send(16'h3000);
    RX_WORD = 16'h6111; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
    tick();
    chk("b2b_done1", 32'(DONE), 32'h1);
    chk("b2b_tx1",   32'(TX_DATA), 32'h111);
    RX_WORD = 16'h6222; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("b2b_c4_done", 32'(DONE), 32'h0);
    tick();
    chk("b2b_c5_done", 32'(DONE), 32'h0);
    tick();
    chk("b2b_done2", 32'(DONE), 32'h1);
    chk("b2b_tx2",   32'(TX_DATA), 32'h222);
    chk("b2b_err",   32'(ERR_CNT), 32'h0);

    // CLRERR executing alongside an overrun: clear wins
    send(16'hF000);
    chk("pre_clr_err", 32'(ERR_CNT), 32'h1);
    RX_WORD = 16'h3000; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
    RX_WORD = 16'hD000; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("clr_vs_ovr", 32'(ERR_CNT), 32'h0);

    for (int i = 0; i < 300; i++) send(16'hE000 | 16'(i));
    chk("err_sat", 32'(ERR_CNT), 32'hFF);

    // Reset in the EXEC cycle of a WRITE aborts it
    RX_WORD = 16'h4777; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(posedge CLK_50);
    #1;
    RST = 1'b0;

    // Prescaler of 4: count during EXEC = floor(edges since release / 4)
    idle(19);
    send(16'h1000); chk("sample_5", 32'(TX_DATA), 32'h005);
    send(16'h8000); chk("abort_reg0", 32'(TX_DATA), 32'h000);
    idle(16356);
    send(16'h1000); chk("sample_fff", 32'(TX_DATA), 32'hFFF);
    send(16'h1000); chk("sample_wrap", 32'(TX_DATA), 32'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
